// File: rtl/prism_aux_datapath.sv
// prism_aux_datapath: countdown and event counters, a variable-length
// shift register and sticky masked interrupts behind a 3-bit register file.
module prism_aux_datapath #(
  parameter int NUM_CNT = 2,
  parameter int CNT_W   = 24,
  parameter int EV_W    = 5,
  parameter int SHIFT_W = 32,
  parameter int IN_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exec,
  input  logic [NUM_CNT-1:0] cnt_load,
  input  logic [NUM_CNT-1:0] cnt_dec,
  input  logic               ev_inc,
  input  logic               ev_clr,
  input  logic               shift_en,
  input  logic [IN_W-1:0]    ser_in,
  input  logic [2:0]         reg_addr,
  input  logic               reg_wr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [NUM_CNT-1:0] cnt_zero,
  output logic               ev_match,
  output logic               shift_out,
  output logic               shift_done,
  output logic               irq
);

  localparam logic [5:0] SW = 6'(SHIFT_W);

  logic               dir_q;
  logic [4:0]         len_q;
  logic [1:0]         insel_q;
  logic [NUM_CNT-1:0] arl_q, zen_q;
  logic               even_q, shen_q;

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [CNT_W-1:0]   pre_q [NUM_CNT];
  logic [CNT_W-1:0]   pre_d [NUM_CNT];

  logic [EV_W-1:0]    evc_q, evc_d, evc_inc, cmp_q, cmp_d;
  logic [SHIFT_W-1:0] sr_q, sr_d, mask, top;
  logic [4:0]         bc_q, bc_d;
  logic               done_q, done_d;

  logic [NUM_CNT-1:0] zp_q, zp_d, zset;
  logic               evp_q, evp_d, evset;
  logic               shp_q, shp_d, shset;
  logic               irq_q;

  logic               wr_ctrl, wr_stat, wr_sr, wr_ev;
  logic [5:0]         lenp1, len_l;
  logic               sin, wrap;

  assign wr_ctrl = reg_wr && (reg_addr == 3'd0);
  assign wr_stat = reg_wr && (reg_addr == 3'd1);
  assign wr_sr   = reg_wr && (reg_addr == 3'd2);
  assign wr_ev   = reg_wr && (reg_addr == 3'd3);

  // Active word length L and masks for bit L-1 and bits below L
  assign lenp1 = {1'b0, len_q} + 6'd1;
  assign len_l = (lenp1 > SW) ? SW : lenp1;
  assign mask  = {SHIFT_W{1'b1}} >> (SW - len_l);
  assign top   = mask ^ (mask >> 1);
  assign wrap  = {1'b0, bc_q} >= (len_l - 6'd1);

  always_comb begin
    sin = ser_in[0];
    for (int k = 0; k < IN_W; k++) begin
      if (insel_q == 2'(k)) sin = ser_in[k];
    end
  end

  always_comb begin
    zset = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      cnt_d[i] = cnt_q[i];
      pre_d[i] = pre_q[i];
      if (reg_wr && reg_addr == 3'(4 + i))
        pre_d[i] = reg_wdata[CNT_W-1:0];
      if (exec) begin
        if (cnt_load[i]) begin
          cnt_d[i] = pre_q[i];
        end else if (cnt_dec[i]) begin
          if (cnt_q[i] > CNT_W'(1)) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end else if (cnt_q[i] == CNT_W'(1)) begin
            cnt_d[i] = '0;
            zset[i]  = 1'b1;
          end else if (arl_q[i]) begin
            cnt_d[i] = pre_q[i];
          end
        end
      end
    end
  end

  assign evc_inc = evc_q + EV_W'(1);

  always_comb begin
    evc_d = evc_q;
    evset = 1'b0;
    cmp_d = wr_ev ? reg_wdata[EV_W-1:0] : cmp_q;
    if (exec) begin
      if (ev_inc && ev_clr) begin
        evset = 1'b1;
      end else if (ev_inc) begin
        evc_d = evc_inc;
        evset = (evc_inc == cmp_q);
      end else if (ev_clr) begin
        evc_d = '0;
      end
    end
  end

  // A CPU load of SHIFT overrides a simultaneous shift entirely
  always_comb begin
    sr_d   = sr_q;
    bc_d   = bc_q;
    done_d = done_q;
    shset  = 1'b0;
    if (wr_sr) begin
      sr_d   = reg_wdata[SHIFT_W-1:0];
      bc_d   = '0;
      done_d = 1'b0;
    end else if (exec && shift_en) begin
      if (dir_q)
        sr_d = ((sr_q & mask) >> 1) | (top & {SHIFT_W{sin}});
      else
        sr_d = ((sr_q << 1) | SHIFT_W'(sin)) & mask;
      if (wrap) begin
        bc_d   = '0;
        done_d = 1'b1;
        shset  = 1'b1;
      end else begin
        bc_d   = bc_q + 5'd1;
        done_d = 1'b0;
      end
    end
  end

  always_comb begin
    zp_d  = (zp_q & ~({NUM_CNT{wr_stat}} & reg_wdata[NUM_CNT-1:0])) | zset;
    evp_d = (evp_q & ~(wr_stat & reg_wdata[8])) | evset;
    shp_d = (shp_q & ~(wr_stat & reg_wdata[9])) | shset;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q   <= 1'b0;
      len_q   <= 5'd7;
      insel_q <= '0;
      arl_q   <= '0;
      zen_q   <= '0;
      even_q  <= 1'b0;
      shen_q  <= 1'b0;
      for (int i = 0; i < NUM_CNT; i++) begin
        cnt_q[i] <= '0;
        pre_q[i] <= '0;
      end
      evc_q   <= '0;
      cmp_q   <= '0;
      sr_q    <= '0;
      bc_q    <= '0;
      done_q  <= 1'b0;
      zp_q    <= '0;
      evp_q   <= 1'b0;
      shp_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        dir_q   <= reg_wdata[0];
        len_q   <= reg_wdata[5:1];
        insel_q <= reg_wdata[7:6];
        arl_q   <= reg_wdata[8 +: NUM_CNT];
        zen_q   <= reg_wdata[16 +: NUM_CNT];
        even_q  <= reg_wdata[24];
        shen_q  <= reg_wdata[25];
      end
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      evc_q  <= evc_d;
      cmp_q  <= cmp_d;
      sr_q   <= sr_d;
      bc_q   <= bc_d;
      done_q <= done_d;
      zp_q   <= zp_d;
      evp_q  <= evp_d;
      shp_q  <= shp_d;
      irq_q  <= (|(zp_q & zen_q)) | (evp_q & even_q) | (shp_q & shen_q);
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      3'd0: begin
        reg_rdata[0]            = dir_q;
        reg_rdata[5:1]          = len_q;
        reg_rdata[7:6]          = insel_q;
        reg_rdata[8 +: NUM_CNT]  = arl_q;
        reg_rdata[16 +: NUM_CNT] = zen_q;
        reg_rdata[24]           = even_q;
        reg_rdata[25]           = shen_q;
      end
      3'd1: begin
        reg_rdata[0 +: NUM_CNT] = zp_q;
        reg_rdata[8]            = evp_q;
        reg_rdata[9]            = shp_q;
      end
      3'd2: reg_rdata[SHIFT_W-1:0] = sr_q;
      3'd3: begin
        reg_rdata[EV_W-1:0]  = evc_q;
        reg_rdata[16 +: EV_W] = cmp_q;
      end
      default: begin
        for (int i = 0; i < NUM_CNT; i++) begin
          if (reg_addr == 3'(4 + i)) reg_rdata[CNT_W-1:0] = cnt_q[i];
        end
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) cnt_zero[i] = (cnt_q[i] == '0);
  end

  assign ev_match   = (evc_q == cmp_q);
  assign shift_out  = dir_q ? sr_q[0] : |(sr_q & top);
  assign shift_done = done_q;
  assign irq        = irq_q;

endmodule
